// File: rtl/omsp_spm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// omsp_spm_sequencer_pkg
// Shared definitions for the SPM protect/unprotect sequencer:
//   - NB_SPMS_DEFAULT : number of SPM slots in the SPM array
//   - spm_seq_state_e : 3-bit sequencer state encoding
//   - next_spm_id()   : SPM ID successor; 0 is reserved, so it wraps to 1
// ---------------------------------------------------------------------------
package omsp_spm_sequencer_pkg;

  localparam int NB_SPMS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } spm_seq_state_e;

  // ID 0 means "no SPM created yet", so the counter skips it on wrap
  function automatic logic [15:0] next_spm_id(input logic [15:0] id);
    return (id == 16'hFFFF) ? 16'h0001 : id + 16'h0001;
  endfunction

endpackage

// File: rtl/omsp_spm_layout_check.sv
// ---------------------------------------------------------------------------
// omsp_spm_layout_check
// Combinational legality check for a requested SPM layout.
// Ports:
//   spm_r12/spm_r13 : public section start / end   (16 bit)
//   spm_r14/spm_r15 : secret section start / end   (16 bit)
//   spms_enabled    : snapshot of slot-enabled flags (NB_SPMS bits)
//   layout_ok       : 1 when both sections are non-empty, disjoint,
//                     and at least one slot is free
// ---------------------------------------------------------------------------
module omsp_spm_layout_check
  import omsp_spm_sequencer_pkg::*;
#(
  parameter int NB_SPMS = NB_SPMS_DEFAULT
) (
  input  logic [15:0]        spm_r12,
  input  logic [15:0]        spm_r13,
  input  logic [15:0]        spm_r14,
  input  logic [15:0]        spm_r15,
  input  logic [NB_SPMS-1:0] spms_enabled,
  output logic               layout_ok
);

  logic public_bad;
  logic secret_bad;
  logic overlap;
  logic array_full;

  assign public_bad = (spm_r12 >= spm_r13);
  assign secret_bad = (spm_r14 >= spm_r15);
  // Half-open ranges [r12,r13) and [r14,r15) intersect
  assign overlap    = (spm_r12 < spm_r15) && (spm_r14 < spm_r13);
  assign array_full = &spms_enabled;

  assign layout_ok  = !(public_bad || secret_bad || overlap || array_full);

endmodule

// File: rtl/omsp_spm_sequencer.sv
// ---------------------------------------------------------------------------
// omsp_spm_sequencer
// Sequences SPM create (protect) and destroy (unprotect) requests towards the
// SPM array: validates the layout, pulses the array update, then confirms the
// array actually changed before reporting completion.
// Ports:
//   mclk, puc_rst_n            : clock, synchronous active-low reset
//   req_protect/req_unprotect  : single-cycle requests (sampled in IDLE only)
//   r12..r15                   : requested layout
//   spms_enabled               : per-slot enabled flags from the array
//   update_spm, enable_spm     : array update strobe and protect/unprotect
//   spm_r12..spm_r15           : latched layout driven to the array
//   busy, done, status         : stall, completion pulse, 1 = failure
//   spm_id                     : ID of the last successfully created SPM
// ---------------------------------------------------------------------------
module omsp_spm_sequencer
  import omsp_spm_sequencer_pkg::*;
#(
  parameter int NB_SPMS = NB_SPMS_DEFAULT
) (
  input  logic               mclk,
  input  logic               puc_rst_n,
  input  logic               req_protect,
  input  logic               req_unprotect,
  input  logic [15:0]        r12,
  input  logic [15:0]        r13,
  input  logic [15:0]        r14,
  input  logic [15:0]        r15,
  input  logic [NB_SPMS-1:0] spms_enabled,
  output logic               update_spm,
  output logic               enable_spm,
  output logic [15:0]        spm_r12,
  output logic [15:0]        spm_r13,
  output logic [15:0]        spm_r14,
  output logic [15:0]        spm_r15,
  output logic               busy,
  output logic               done,
  output logic               status,
  output logic [15:0]        spm_id
);

  spm_seq_state_e     state_q;
  spm_seq_state_e     state_d;
  logic               op_protect_q;
  logic               enable_q;
  logic               fail_q;
  logic [NB_SPMS-1:0] snap_q;
  logic [15:0]        spm_id_q;
  logic               layout_ok;
  logic               settle_ok;

  omsp_spm_layout_check #(
    .NB_SPMS (NB_SPMS)
  ) u_layout_check (
    .spm_r12      (spm_r12),
    .spm_r13      (spm_r13),
    .spm_r14      (spm_r14),
    .spm_r15      (spm_r15),
    .spms_enabled (snap_q),
    .layout_ok    (layout_ok)
  );

  // The array must show a newly set slot (protect) or a newly cleared slot
  // (unprotect) relative to the snapshot for the operation to count.
  assign settle_ok = op_protect_q ? |(spms_enabled & ~snap_q)
                                  : |(~spms_enabled & snap_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_unprotect)    state_d = ST_UPDATE;
        else if (req_protect) state_d = ST_CHECK;
      end
      ST_CHECK:  state_d = layout_ok ? ST_UPDATE : ST_DONE;
      ST_UPDATE: state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operation context; spm_r* are only reloaded when a protect is accepted
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q      <= ST_IDLE;
      op_protect_q <= 1'b0;
      enable_q     <= 1'b0;
      fail_q       <= 1'b0;
      snap_q       <= '0;
      spm_r12      <= 16'h0000;
      spm_r13      <= 16'h0000;
      spm_r14      <= 16'h0000;
      spm_r15      <= 16'h0000;
      spm_id_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_unprotect) begin
            op_protect_q <= 1'b0;
            fail_q       <= 1'b0;
            snap_q       <= spms_enabled;
          end else if (req_protect) begin
            op_protect_q <= 1'b1;
            fail_q       <= 1'b0;
            snap_q       <= spms_enabled;
            spm_r12      <= r12;
            spm_r13      <= r13;
            spm_r14      <= r14;
            spm_r15      <= r15;
          end
        end
        ST_CHECK: begin
          if (layout_ok) enable_q <= 1'b1;
          else           fail_q   <= 1'b1;
        end
        ST_SETTLE: begin
          if (!settle_ok)        fail_q   <= 1'b1;
          else if (op_protect_q) spm_id_q <= next_spm_id(spm_id_q);
        end
        ST_DONE: enable_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign update_spm = (state_q == ST_UPDATE);
  assign enable_spm = enable_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign status     = done & fail_q;
  assign spm_id     = spm_id_q;

endmodule

// File: doc/omsp_spm_sequencer.md
OMSP_SPM_SEQUENCER -- requirements
Module: omsp_spm_sequencer

Interface
REQ-001 Parameter: NB_SPMS, default 4, number of SPM slots in the array, taken from the shared defines.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 mclk  input  1  system clock; all state updates on rising edge.
REQ-004 puc_rst_n  input  1  synchronous active-low reset.
REQ-005 req_protect  input  1  single-cycle request to create an SPM from r12..r15.
REQ-006 req_unprotect  input  1  single-cycle request to destroy the SPM owning the current PC.
REQ-007 r12, r13, r14, r15  input  16 each  layout: public start/end, secret start/end.
REQ-008 spms_enabled  input  NB_SPMS  per-slot enabled flags from the SPM array.
REQ-009 update_spm  output  1  update strobe to the SPM array.
REQ-010 enable_spm  output  1  1 = protect, 0 = unprotect; qualifies update_spm.
REQ-011 spm_r12, spm_r13, spm_r14, spm_r15  output  16 each  latched layout driven to the array.
REQ-012 busy  output  1  frontend stall; high while an operation is in flight.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 status  output  1  0 = success, 1 = failure; valid when done = 1.
REQ-015 spm_id  output  16  ID of the last successfully created SPM.

Function
REQ-016 States: IDLE, CHECK, UPDATE, SETTLE, DONE; one state per cycle except IDLE.
REQ-017 Requests are sampled only in IDLE.
  - Requests in any other state are ignored, not queued.
  - If both requests are high together, unprotect wins.
REQ-018 Protect accepted in IDLE:
  - Latch r12..r15 into spm_r12..spm_r15.
  - Snapshot spms_enabled.
  - Go to CHECK.
REQ-019 Unprotect accepted in IDLE: snapshot spms_enabled; go to UPDATE. spm_r* are left unchanged.
REQ-020 CHECK fails the protect under any of these conditions (all 16-bit unsigned compares):
  - spm_r12 >= spm_r13
  - spm_r14 >= spm_r15
  - ranges overlap: spm_r12 < spm_r15 and spm_r14 < spm_r13
  - all snapshot bits are set (array full)
REQ-021 CHECK pass goes to UPDATE. CHECK fail goes to DONE with status = 1 and no update_spm pulse.
REQ-022 UPDATE: update_spm = 1 for exactly one cycle; enable_spm = 1 for protect, 0 for unprotect.
REQ-023 enable_spm holds its value from UPDATE through DONE and is 0 in IDLE.
REQ-024 SETTLE, protect: success iff spms_enabled has at least one bit set that was clear in the snapshot.
REQ-025 SETTLE, unprotect: success iff at least one bit cleared relative to the snapshot.
REQ-026 SETTLE failure sets status = 1; then go to DONE.
REQ-027 DONE: done = 1 and status is valid for one cycle; return to IDLE.
REQ-028 busy = 1 in CHECK, UPDATE, SETTLE and DONE; busy = 0 in IDLE.
REQ-029 Latency from request cycle T (IDLE):
  - protect: done at T+4
  - unprotect: done at T+3
  - protect rejected in CHECK: done at T+2
REQ-030 spm_id counter:
  - Increments by 1 in DONE on protect success only; spm_id shows the new value in the same cycle as done.
  - Wraps 0xFFFF -> 0x0001; 0 is never issued after reset.
REQ-031 spm_r* hold their value outside a protect operation; they are reloaded only on protect acceptance.

Reset
REQ-032 On a mclk edge with puc_rst_n = 0:
  - state = IDLE
  - update_spm, enable_spm, busy, done, status = 0
  - spm_r12..spm_r15 = 0x0000
  - spm_id = 0x0000
  - spms_enabled snapshot cleared
REQ-033 Reset asserted mid-operation, including in UPDATE, aborts at that edge: no further update_spm pulse and no done pulse.

Structure
REQ-034 NB_SPMS and the state encodings (3-bit localparams exported as defines) live in the shared openMSP430_defines.v.
REQ-035 Layout legality (REQ-020 compares) is one combinational sub-module, omsp_spm_layout_check, with inputs spm_r12..spm_r15 and spms_enabled and output layout_ok.
REQ-036 This block instantiates omsp_spm_layout_check only; the SPM array stays in the existing control block, which is fed by update_spm, enable_spm and spm_r*.

Verification
REQ-037 Protect success: r12=0x1000, r13=0x1100, r14=0x2000, r15=0x2100, spms_enabled=0000, array sets bit0 after UPDATE -> update_spm high at T+2 only, enable_spm=1, done at T+4, status=0, spm_id=0x0001.
REQ-038 Bad layout: r12=0x1100, r13=0x1000 -> no update_spm, done at T+2, status=1, spm_id unchanged.
REQ-039 Overlap and full: r12=0x1000, r13=0x2080, r14=0x2000, r15=0x2100 -> status=1; valid layout with spms_enabled=1111 -> status=1, no update_spm.
REQ-040 Unprotect: spms_enabled=0011 then 0001 after UPDATE -> enable_spm=0, done at T+3, status=0; with no bit cleared -> status=1.
REQ-041 Collisions and reset:
  - req_protect and req_unprotect together in IDLE -> unprotect path.
  - Requests while busy -> ignored.
  - puc_rst_n=0 during UPDATE -> all outputs 0 next cycle, no done pulse.
REQ-042 ID wrap: preload spm_id=0xFFFF via 65535 successful protects (or force) -> next success yields spm_id=0x0001.
